elevator_scan_ctrl: RTL and testbench

Parametrised elevator car controller for an N-floor shaft, successor to the fixed 8-floor controller. It latches cabin and hall call buttons, serves them in SCAN (collective) order, and times floor-to-floor travel and door dwell. Its outputs drive the motor (`engine`), door actuator (`door`), floor indicator and call-button lamps, and it sits directly between the button panel inputs and the car actuators.

---
 rtl/elevator_pkg.sv | 22 ++
 rtl/elevator_call_latch.sv | 77 +++++++
 rtl/elevator_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings for the SCAN elevator controller: FSM states and the
// actuator command values driven onto the engine and door outputs.
package elevator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE_UP   = 3'd1,
        ST_MOVE_DOWN = 3'd2,
        ST_OPEN      = 3'd3,
        ST_WAIT      = 3'd4,
        ST_CLOSE     = 3'd5
    } state_t;

    localparam logic [1:0] ENGINE_IDLE = 2'd0;
    localparam logic [1:0] ENGINE_DOWN = 2'd1;
    localparam logic [1:0] ENGINE_UP   = 2'd2;

    localparam logic [1:0] DOOR_IDLE  = 2'd0;
    localparam logic [1:0] DOOR_OPEN  = 2'd1;
    localparam logic [1:0] DOOR_CLOSE = 2'd2;

endpackage

// File: rtl/elevator_call_latch.sv
// Per-floor call lamps (cabin, hall-up, hall-down) with set-over-clear
// priority, plus the position reductions the SCAN FSM decides on:
// calls above/below/at the current floor and beyond the neighbouring floors.
module elevator_call_latch
    import elevator_pkg::*;
#(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = $clog2(FLOORS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               hold_here,
    input  logic [FLOORS-1:0]  btn_num_in,
    input  logic [FLOORS-1:0]  btn_up_out,
    input  logic [FLOORS-1:0]  btn_down_out,
    input  logic [FLOORS-1:0]  clr_in,
    input  logic [FLOORS-1:0]  clr_up,
    input  logic [FLOORS-1:0]  clr_down,
    output logic [FLOORS-1:0]  lamp_in,
    output logic [FLOORS-1:0]  lamp_up,
    output logic [FLOORS-1:0]  lamp_down,
    output logic               above,
    output logic               below,
    output logic               here,
    output logic               above_beyond,
    output logic               below_beyond
);

    logic [FLOORS-1:0] pending;
    logic [FLOORS-1:0] gt_cur;
    logic [FLOORS-1:0] lt_cur;
    logic [FLOORS-1:0] gt_next;
    logic [FLOORS-1:0] lt_next;
    logic [FLOORS-1:0] allow;
    logic [FLOORS-1:0] up_ok;
    logic [FLOORS-1:0] down_ok;

    // Position masks relative to the current floor and to its neighbours.
    // A press at the current floor while the door is open is already served,
    // so it is masked out of the set path.
    genvar gi;
    generate
        for (gi = 0; gi < FLOORS; gi++) begin : g_floor
            assign gt_cur[gi]  = (gi > int'(floor));
            assign lt_cur[gi]  = (gi < int'(floor));
            assign gt_next[gi] = (gi > int'(floor) + 1);
            assign lt_next[gi] = (gi + 1 < int'(floor));
            assign allow[gi]   = !(hold_here && (gi == int'(floor)));
        end
    endgenerate

    // No up call exists at the top floor and no down call at the ground floor.
    assign up_ok   = allow & ~(FLOORS'(1) << (FLOORS - 1));
    assign down_ok = allow & ~FLOORS'(1);

    assign pending      = lamp_in | lamp_up | lamp_down;
    assign above        = |(pending & gt_cur);
    assign below        = |(pending & lt_cur);
    assign here         = pending[floor];
    assign above_beyond = |(pending & gt_next);
    assign below_beyond = |(pending & lt_next);

    // Lamp registers: a new press wins over a service clear on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lamp_in   <= '0;
            lamp_up   <= '0;
            lamp_down <= '0;
        end else begin
            lamp_in   <= (lamp_in   & ~clr_in)   | (btn_num_in   & allow);
            lamp_up   <= (lamp_up   & ~clr_up)   | (btn_up_out   & up_ok);
            lamp_down <= (lamp_down & ~clr_down) | (btn_down_out & down_ok);
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN (collective) elevator car controller: serves latched calls in the
// current direction before reversing, times floor travel and door dwell,
// and drives registered engine/door/indicator outputs.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS        = 8,
    parameter int FLOOR_W       = $clog2(FLOORS),
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               open_btn,
    input  logic               close_btn,
    input  logic               overload,
    input  logic [FLOORS-1:0]  btn_num_in,
    input  logic [FLOORS-1:0]  btn_up_out,
    input  logic [FLOORS-1:0]  btn_down_out,
    output logic [1:0]         engine,
    output logic [1:0]         door,
    output logic [FLOOR_W-1:0] level_display,
    output logic               dir_up,
    output logic [FLOORS-1:0]  lamp_in,
    output logic [FLOORS-1:0]  lamp_up,
    output logic [FLOORS-1:0]  lamp_down
);

    localparam int TRAVEL_W = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DOOR_W   = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
    // Counters run down to zero, so loading N-1 gives exactly N cycles.
    localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]   DOOR_LOAD   = DOOR_W'(DOOR_CYCLES - 1);

    state_t              state;
    logic [FLOOR_W-1:0]  floor;
    logic [TRAVEL_W-1:0] travel_cnt;
    logic [DOOR_W-1:0]   dwell_cnt;

    logic [FLOOR_W-1:0]  floor_up;
    logic [FLOOR_W-1:0]  floor_down;
    logic [FLOORS-1:0]   oh_cur;
    logic [FLOORS-1:0]   oh_up;
    logic [FLOORS-1:0]   oh_down;
    logic                travel_done;
    logic                stop_up;
    logic                stop_down;
    logic                flip_up;
    logic                flip_down;
    logic                hold_here;
    logic                above;
    logic                below;
    logic                here;
    logic                above_beyond;
    logic                below_beyond;
    logic [FLOORS-1:0]   clr_in;
    logic [FLOORS-1:0]   clr_up;
    logic [FLOORS-1:0]   clr_down;

    assign level_display = floor;
    assign hold_here     = (state == ST_OPEN) || (state == ST_WAIT);

    // Neighbour floors are only consulted while moving toward them, so the
    // wrap at the shaft ends is never used.
    assign floor_up    = floor + FLOOR_W'(1);
    assign floor_down  = floor - FLOOR_W'(1);
    assign oh_cur      = FLOORS'(1) << floor;
    assign oh_up       = FLOORS'(1) << floor_up;
    assign oh_down     = FLOORS'(1) << floor_down;
    assign travel_done = (travel_cnt == '0);

    // Stop at the arriving floor for a cabin call, a same-direction hall call,
    // or when nothing lies further on; in the last case an opposite hall call
    // there is picked up and the service direction reverses.
    assign flip_up   = !above_beyond && lamp_down[floor_up];
    assign stop_up   = lamp_in[floor_up] || lamp_up[floor_up] || !above_beyond;
    assign flip_down = !below_beyond && lamp_up[floor_down];
    assign stop_down = lamp_in[floor_down] || lamp_down[floor_down] || !below_beyond;

    elevator_call_latch #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_calls (
        .clk          (clk),
        .reset        (reset),
        .floor        (floor),
        .hold_here    (hold_here),
        .btn_num_in   (btn_num_in),
        .btn_up_out   (btn_up_out),
        .btn_down_out (btn_down_out),
        .clr_in       (clr_in),
        .clr_up       (clr_up),
        .clr_down     (clr_down),
        .lamp_in      (lamp_in),
        .lamp_up      (lamp_up),
        .lamp_down    (lamp_down),
        .above        (above),
        .below        (below),
        .here         (here),
        .above_beyond (above_beyond),
        .below_beyond (below_beyond)
    );

    // Service clears: lamps are dropped on the edge that opens the door.
    always_comb begin
        clr_in   = '0;
        clr_up   = '0;
        clr_down = '0;
        case (state)
            ST_IDLE: begin
                if (here) begin
                    clr_in   = oh_cur;
                    clr_up   = oh_cur;
                    clr_down = oh_cur;
                end
            end
            ST_MOVE_UP: begin
                if (travel_done && stop_up) begin
                    clr_in = oh_up;
                    clr_up = oh_up;
                    if (flip_up) begin
                        clr_down = oh_up;
                    end
                end
            end
            ST_MOVE_DOWN: begin
                if (travel_done && stop_down) begin
                    clr_in   = oh_down;
                    clr_down = oh_down;
                    if (flip_down) begin
                        clr_up = oh_down;
                    end
                end
            end
            default: ;
        endcase
    end

    // Car FSM with travel/dwell timing and registered actuator commands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            floor      <= '0;
            dir_up     <= 1'b1;
            travel_cnt <= '0;
            dwell_cnt  <= '0;
            engine     <= ENGINE_IDLE;
            door       <= DOOR_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (here) begin
                        state <= ST_OPEN;
                        door  <= DOOR_OPEN;
                    end else if (dir_up && above) begin
                        state      <= ST_MOVE_UP;
                        engine     <= ENGINE_UP;
                        travel_cnt <= TRAVEL_LOAD;
                    end else if (below) begin
                        state      <= ST_MOVE_DOWN;
                        engine     <= ENGINE_DOWN;
                        dir_up     <= 1'b0;
                        travel_cnt <= TRAVEL_LOAD;
                    end else if (above) begin
                        state      <= ST_MOVE_UP;
                        engine     <= ENGINE_UP;
                        dir_up     <= 1'b1;
                        travel_cnt <= TRAVEL_LOAD;
                    end
                end
                ST_MOVE_UP: begin
                    if (travel_done) begin
                        floor <= floor_up;
                        if (stop_up) begin
                            state  <= ST_OPEN;
                            engine <= ENGINE_IDLE;
                            door   <= DOOR_OPEN;
                            if (flip_up) begin
                                dir_up <= 1'b0;
                            end
                        end else begin
                            travel_cnt <= TRAVEL_LOAD;
                        end
                    end else begin
                        travel_cnt <= travel_cnt - TRAVEL_W'(1);
                    end
                end
                ST_MOVE_DOWN: begin
                    if (travel_done) begin
                        floor <= floor_down;
                        if (stop_down) begin
                            state  <= ST_OPEN;
                            engine <= ENGINE_IDLE;
                            door   <= DOOR_OPEN;
                            if (flip_down) begin
                                dir_up <= 1'b1;
                            end
                        end else begin
                            travel_cnt <= TRAVEL_LOAD;
                        end
                    end else begin
                        travel_cnt <= travel_cnt - TRAVEL_W'(1);
                    end
                end
                ST_OPEN: begin
                    state     <= ST_WAIT;
                    door      <= DOOR_IDLE;
                    dwell_cnt <= DOOR_LOAD;
                end
                ST_WAIT: begin
                    // Open request and overload both restart the dwell and
                    // take priority over a close request.
                    if (overload || open_btn) begin
                        dwell_cnt <= DOOR_LOAD;
                    end else if (close_btn || (dwell_cnt == '0)) begin
                        state <= ST_CLOSE;
                        door  <= DOOR_CLOSE;
                    end else begin
                        dwell_cnt <= dwell_cnt - DOOR_W'(1);
                    end
                end
                ST_CLOSE: begin
                    if (open_btn || overload) begin
                        state <= ST_OPEN;
                        door  <= DOOR_OPEN;
                    end else begin
                        state <= ST_IDLE;
                        door  <= DOOR_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    engine <= ENGINE_IDLE;
                    door   <= DOOR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl: the driver applies directed and
// random button traffic, steps a floor-level behavioural model and queues the
// expected outputs; a monitor compares the DUT after every rising edge.
module tb_elevator_scan_ctrl;

    localparam int F  = 8;
    localparam int FW = $clog2(F);
    localparam int T  = 16;
    localparam int D  = 32;

    // Model activity codes (independent of the RTL encoding).
    localparam int P_IDLE  = 0;
    localparam int P_UP    = 1;
    localparam int P_DOWN  = 2;
    localparam int P_OPEN  = 3;
    localparam int P_WAIT  = 4;
    localparam int P_CLOSE = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          open_btn = 1'b0;
    logic          close_btn = 1'b0;
    logic          overload = 1'b0;
    logic [F-1:0]  btn_num_in = '0;
    logic [F-1:0]  btn_up_out = '0;
    logic [F-1:0]  btn_down_out = '0;
    logic [1:0]    engine;
    logic [1:0]    door;
    logic [FW-1:0] level_display;
    logic          dir_up;
    logic [F-1:0]  lamp_in;
    logic [F-1:0]  lamp_up;
    logic [F-1:0]  lamp_down;

    elevator_scan_ctrl #(
        .FLOORS        (F),
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .open_btn      (open_btn),
        .close_btn     (close_btn),
        .overload      (overload),
        .btn_num_in    (btn_num_in),
        .btn_up_out    (btn_up_out),
        .btn_down_out  (btn_down_out),
        .engine        (engine),
        .door          (door),
        .level_display (level_display),
        .dir_up        (dir_up),
        .lamp_in       (lamp_in),
        .lamp_up       (lamp_up),
        .lamp_down     (lamp_down)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    eng;
        logic [1:0]    dr;
        logic [FW-1:0] lvl;
        logic          dir;
        logic [F-1:0]  li;
        logic [F-1:0]  lu;
        logic [F-1:0]  ld;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Behavioural model state.
    int       m_phase;
    int       m_floor;
    int       m_left;
    int       m_wait;
    bit       m_dir;
    bit [F-1:0] m_cab;
    bit [F-1:0] m_up;
    bit [F-1:0] m_dn;

    function automatic bit calls_at(input int f);
        return m_cab[f] | m_up[f] | m_dn[f];
    endfunction

    function automatic bit calls_above(input int x);
        for (int f = x + 1; f < F; f++) if (calls_at(f)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit calls_below(input int x);
        for (int f = 0; f < x; f++) if (calls_at(f)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_floor = 0;
        m_left  = 0;
        m_wait  = 0;
        m_dir   = 1'b1;
        m_cab   = '0;
        m_up    = '0;
        m_dn    = '0;
    endtask

    // One clock edge of the reference car, given the inputs seen at that edge.
    task automatic model_step(input logic [F-1:0] num, input logic [F-1:0] up,
                              input logic [F-1:0] dn, input bit op, input bit cl,
                              input bit ov);
        bit [F-1:0] s_cab;
        bit [F-1:0] s_up;
        bit [F-1:0] s_dn;
        bit         door_open_now;
        int         here_floor;
        int         nf;
        bit         going_up;
        bit         wanted;
        bit         nothing_beyond;
        s_cab = '0;
        s_up  = '0;
        s_dn  = '0;
        door_open_now = (m_phase == P_OPEN) || (m_phase == P_WAIT);
        here_floor    = m_floor;
        case (m_phase)
            P_IDLE: begin
                if (calls_at(m_floor)) begin
                    s_cab[m_floor] = 1'b1;
                    s_up[m_floor]  = 1'b1;
                    s_dn[m_floor]  = 1'b1;
                    m_phase = P_OPEN;
                end else if (m_dir && calls_above(m_floor)) begin
                    m_phase = P_UP;
                    m_left  = T;
                end else if (calls_below(m_floor)) begin
                    m_phase = P_DOWN;
                    m_dir   = 1'b0;
                    m_left  = T;
                end else if (calls_above(m_floor)) begin
                    m_phase = P_UP;
                    m_dir   = 1'b1;
                    m_left  = T;
                end
            end
            P_UP, P_DOWN: begin
                going_up = (m_phase == P_UP);
                m_left--;
                if (m_left == 0) begin
                    nf = going_up ? m_floor + 1 : m_floor - 1;
                    m_floor = nf;
                    wanted = m_cab[nf] | (going_up ? m_up[nf] : m_dn[nf]);
                    nothing_beyond = going_up ? !calls_above(nf) : !calls_below(nf);
                    if (wanted || nothing_beyond) begin
                        s_cab[nf] = 1'b1;
                        if (going_up) s_up[nf] = 1'b1;
                        else          s_dn[nf] = 1'b1;
                        if (nothing_beyond && (going_up ? m_dn[nf] : m_up[nf])) begin
                            if (going_up) s_dn[nf] = 1'b1;
                            else          s_up[nf] = 1'b1;
                            m_dir = !going_up;
                        end
                        m_phase = P_OPEN;
                    end else begin
                        m_left = T;
                    end
                end
            end
            P_OPEN: begin
                m_phase = P_WAIT;
                m_wait  = D;
            end
            P_WAIT: begin
                if (ov || op) begin
                    m_wait = D;
                end else if (cl) begin
                    m_phase = P_CLOSE;
                end else begin
                    m_wait--;
                    if (m_wait == 0) m_phase = P_CLOSE;
                end
            end
            default: begin
                m_phase = (op || ov) ? P_OPEN : P_IDLE;
            end
        endcase
        for (int f = 0; f < F; f++) begin
            bit blocked;
            blocked  = door_open_now && (f == here_floor);
            m_cab[f] = (m_cab[f] && !s_cab[f]) || (num[f] && !blocked);
            m_up[f]  = (m_up[f] && !s_up[f]) || (up[f] && !blocked && (f != F - 1));
            m_dn[f]  = (m_dn[f] && !s_dn[f]) || (dn[f] && !blocked && (f != 0));
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.eng = (m_phase == P_UP) ? 2'd2 : (m_phase == P_DOWN) ? 2'd1 : 2'd0;
        o.dr  = (m_phase == P_OPEN) ? 2'd1 : (m_phase == P_CLOSE) ? 2'd2 : 2'd0;
        o.lvl = FW'(m_floor);
        o.dir = m_dir;
        o.li  = m_cab;
        o.lu  = m_up;
        o.ld  = m_dn;
        return o;
    endfunction

    // Reset acts asynchronously: outputs must be back at rest before any edge.
    task automatic check_reset_now();
        total++;
        if (engine !== 2'd0 || door !== 2'd0 || level_display !== '0 || dir_up !== 1'b1 ||
            lamp_in !== '0 || lamp_up !== '0 || lamp_down !== '0) begin
            bad++;
            $display("FAIL reset_now got eng=%0d door=%0d lvl=%0d dir=%0d in=%h up=%h dn=%h required all zero, dir=1",
                     engine, door, level_display, dir_up, lamp_in, lamp_up, lamp_down);
        end
    endtask

    // Apply one cycle of inputs at the falling edge and queue the expectation.
    task automatic tick(input logic [F-1:0] num, input logic [F-1:0] up,
                        input logic [F-1:0] dn, input bit op, input bit cl,
                        input bit ov, input bit rs);
        @(negedge clk);
        btn_num_in   = num;
        btn_up_out   = up;
        btn_down_out = dn;
        open_btn     = op;
        close_btn    = cl;
        overload     = ov;
        reset        = rs;
        if (!rs) begin
            #1;
            check_reset_now();
            model_reset();
        end else begin
            model_step(num, up, dn, op, cl, ov);
        end
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n);
        repeat (n) tick('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_until(input int ph, input int fl, input int budget, input string what);
        int n;
        n = 0;
        while (!(m_phase == ph && m_floor == fl) && n < budget) begin
            idle(1);
            n++;
        end
        if (!(m_phase == ph && m_floor == fl)) begin
            total++;
            bad++;
            $display("FAIL %s timeout after %0d cycles (phase=%0d floor=%0d, required phase=%0d floor=%0d)",
                     what, n, m_phase, m_floor, ph, fl);
        end
    endtask

    function automatic logic [F-1:0] bitmask(input int f);
        logic [F-1:0] m;
        m = '0;
        m[f] = 1'b1;
        return m;
    endfunction

    // Monitor: compare every DUT output just after each rising edge.
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {engine, door, level_display, dir_up, lamp_in, lamp_up, lamp_down};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got eng=%0d door=%0d lvl=%0d dir=%0d in=%h up=%h dn=%h required eng=%0d door=%0d lvl=%0d dir=%0d in=%h up=%h dn=%h",
                             cyc, g.eng, g.dr, g.lvl, g.dir, g.li, g.lu, g.ld,
                             e.eng, e.dr, e.lvl, e.dir, e.li, e.lu, e.ld);
                end
                cyc++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        logic [F-1:0] rn;
        logic [F-1:0] ru;
        logic [F-1:0] rd;
        bit           rop;
        bit           rcl;
        bit           rov;
        bit           rrs;
        int           kind;
        int           fl;

        model_reset();
        repeat (3) tick('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        $display("scenario cabin call to floor 3");
        tick(bitmask(3), '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3 * T + D + 10);

        $display("scenario cabin 5 and hall-down 2 from ground");
        repeat (2) tick('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(bitmask(5), '0, bitmask(2), 1'b0, 1'b0, 1'b0, 1'b1);
        run_until(P_WAIT, 5, 400, "reach_5");
        run_until(P_WAIT, 2, 400, "reach_2");
        idle(D + 5);

        $display("scenario overload held at floor 4");
        tick(bitmask(4), '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_until(P_WAIT, 4, 400, "reach_4");
        repeat (100) tick('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(D + 10);

        $display("scenario early close then reopen at floor 1");
        tick(bitmask(1), '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_until(P_WAIT, 1, 400, "reach_1");
        idle(2);
        tick('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick('0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick('0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(D + 10);

        $display("scenario shaft ends and ignored hall bits");
        tick('0, bitmask(F - 1), bitmask(0), 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        tick(bitmask(F - 1), '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_until(P_WAIT, F - 1, 600, "reach_top");
        tick('0, bitmask(0), '0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_until(P_WAIT, 0, 600, "reach_ground");
        idle(D + 5);

        $display("scenario reset during upward travel");
        tick(bitmask(6), '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(T + 10);
        tick(bitmask(2), '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        $display("scenario random traffic");
        for (int i = 0; i < 12000; i++) begin
            rn = '0;
            ru = '0;
            rd = '0;
            if ($urandom_range(0, 7) == 0) begin
                kind = $urandom_range(0, 2);
                fl   = $urandom_range(0, F - 1);
                if (kind == 0)      rn[fl] = 1'b1;
                else if (kind == 1) ru[fl] = 1'b1;
                else                rd[fl] = 1'b1;
            end
            rop = ($urandom_range(0, 63) == 0);
            rcl = ($urandom_range(0, 15) == 0);
            rov = ($urandom_range(0, 79) == 0);
            rrs = ($urandom_range(0, 2999) != 0);
            tick(rn, ru, rd, rop, rcl, rov, rrs);
        end
        idle(3);

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
